// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit counter only has to reach WIDTH-1, never WIDTH.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the serial adder.
interface serial_adder_ctrl_if
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
    logic             BUSY;

    modport slave (
        input  IN_VALID, A, B, CIN, OUT_READY,
        output IN_READY, OUT_VALID, SUM, COUT, BUSY
    );

    modport master (
        output IN_VALID, A, B, CIN, OUT_READY,
        input  IN_READY, OUT_VALID, SUM, COUT, BUSY
    );
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell used by the serial datapath.
module serial_adder_ctrl_fa (
    input  logic A,
    input  logic B,
    input  logic C0,
    output logic S,
    output logic C
);
    logic w_p;

    assign w_p = A ^ B;
    assign S   = w_p ^ C0;
    assign C   = (A & B) | (C0 & w_p);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full adder cell,
// carry held in a flop between bits, result held until consumed.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)(
    input  logic               CLK,
    input  logic               RST_N,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_accept;
    logic             w_last;

    serial_adder_ctrl_fa u_full_adder (
        .A  (r_a[0]),
        .B  (r_b[0]),
        .C0 (r_carry),
        .S  (w_s),
        .C  (w_c)
    );

    assign w_accept = (r_state == S_IDLE) && bus.IN_VALID;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.IN_VALID) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.OUT_READY) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_carry <= bus.CIN;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_carry <= w_c;
            // Hold on the last bit so the counter never wraps.
            if (!w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.IN_READY  = (r_state == S_IDLE);
    assign bus.OUT_VALID = (r_state == S_DONE);
    assign bus.BUSY      = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign bus.SUM       = r_sum;
    assign bus.COUT      = r_carry;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized bench for serial_adder_ctrl at WIDTH=8 and WIDTH=2,
// checked against plain integer addition.
module tb_serial_adder_ctrl;
    import serial_adder_ctrl_pkg::*;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 CLK = ~CLK;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus8.slave)
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus2.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input int bp);
        logic [8:0] exp;
        int edges;
        bit seen;
        exp = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        for (int i = 0; i < 40 && !bus8.IN_READY; i++) tick();
        chk("rdy8_before", bus8.IN_READY, 1);
        bus8.A = a;
        bus8.B = b;
        bus8.CIN = cin;
        bus8.IN_VALID = 1'b1;
        tick();
        edges = 1;
        seen = 1'b0;
        while (!seen && edges < 40) begin
            chk("rdy8_busy", bus8.IN_READY, 0);
            bus8.IN_VALID = 1'($urandom_range(0, 1));
            bus8.A = 8'($urandom);
            bus8.B = 8'($urandom);
            bus8.CIN = 1'($urandom);
            bus8.OUT_READY = 1'($urandom_range(0, 1));
            tick();
            edges++;
            seen = bus8.OUT_VALID;
        end
        bus8.IN_VALID = 1'b0;
        // Accepting edge plus WIDTH shift edges.
        chk("lat8", edges, 9);
        chk("sum8", bus8.SUM, exp[7:0]);
        chk("cout8", bus8.COUT, exp[8]);
        bus8.OUT_READY = 1'b0;
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("hold_valid8", bus8.OUT_VALID, 1);
            chk("hold_sum8", bus8.SUM, exp[7:0]);
            chk("hold_cout8", bus8.COUT, exp[8]);
            chk("hold_rdy8", bus8.IN_READY, 0);
        end
        bus8.OUT_READY = 1'b1;
        tick();
        bus8.OUT_READY = 1'b0;
        chk("drain_valid8", bus8.OUT_VALID, 0);
        chk("drain_rdy8", bus8.IN_READY, 1);
        chk("drain_busy8", bus8.BUSY, 0);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b,
                       input logic cin);
        logic [2:0] exp;
        int edges;
        bit seen;
        exp = {1'b0, a} + {1'b0, b} + {2'd0, cin};
        chk("rdy2_before", bus2.IN_READY, 1);
        bus2.A = a;
        bus2.B = b;
        bus2.CIN = cin;
        bus2.IN_VALID = 1'b1;
        tick();
        edges = 1;
        seen = 1'b0;
        while (!seen && edges < 20) begin
            bus2.IN_VALID = ~bus2.IN_VALID;
            bus2.A = 2'($urandom);
            bus2.B = 2'($urandom);
            bus2.CIN = 1'($urandom);
            tick();
            edges++;
            seen = bus2.OUT_VALID;
        end
        bus2.IN_VALID = 1'b0;
        chk("lat2", edges, 3);
        chk("res2", {bus2.COUT, bus2.SUM}, exp);
        bus2.OUT_READY = 1'b1;
        tick();
        bus2.OUT_READY = 1'b0;
        chk("drain2", bus2.IN_READY, 1);
    endtask

    initial begin
        bus8.IN_VALID = 1'b0;
        bus8.A = '0;
        bus8.B = '0;
        bus8.CIN = 1'b0;
        bus8.OUT_READY = 1'b0;
        bus2.IN_VALID = 1'b0;
        bus2.A = '0;
        bus2.B = '0;
        bus2.CIN = 1'b0;
        bus2.OUT_READY = 1'b0;

        tick();
        tick();
        chk("rst_rdy", bus8.IN_READY, 1);
        chk("rst_valid", bus8.OUT_VALID, 0);
        chk("rst_sum", bus8.SUM, 0);
        chk("rst_cout", bus8.COUT, 0);
        chk("rst_busy", bus8.BUSY, 0);
        RST_N = 1'b1;
        tick();

        op8(8'h5A, 8'h3C, 1'b1, 0);
        op8(8'hFF, 8'h01, 1'b0, 0);
        op8(8'hFF, 8'hFF, 1'b1, 0);
        op8(8'hA5, 8'h5B, 1'b0, 5);

        // Abort in the middle of shifting.
        bus8.A = 8'h77;
        bus8.B = 8'h11;
        bus8.CIN = 1'b1;
        bus8.IN_VALID = 1'b1;
        tick();
        bus8.IN_VALID = 1'b0;
        tick();
        tick();
        tick();
        RST_N = 1'b0;
        #1;
        chk("abort_rdy", bus8.IN_READY, 1);
        chk("abort_valid", bus8.OUT_VALID, 0);
        chk("abort_sum", bus8.SUM, 0);
        chk("abort_cout", bus8.COUT, 0);
        chk("abort_busy", bus8.BUSY, 0);
        tick();
        RST_N = 1'b1;
        tick();
        op8(8'h10, 8'h20, 1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)));
        end

        for (int v = 0; v < 32; v++) begin
            op2(2'(v >> 3), 2'(v >> 1), 1'(v));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
